// File: rtl/vga_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : vga_layer_mixer
// Purpose  : VGA raster timing, layer pixel-address broadcast and fixed
//            priority compositor (me > enemy > bullet > background).
//            Optional MIXER_BORDER_EN paints the active-area edge white.
// Revision : 1.0 - initial release
// ============================================================================
module vga_layer_mixer #(
  parameter int PIX_DIV = 10,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int COLOR_W = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [9:0]         req_x_o,
  output logic [9:0]         req_y_o,
  input  logic [COLOR_W-1:0] me_rgb_i,
  input  logic               me_alpha_i,
  input  logic [COLOR_W-1:0] enemy_rgb_i,
  input  logic               enemy_alpha_i,
  input  logic [COLOR_W-1:0] bullet_rgb_i,
  input  logic               bullet_alpha_i,
  output logic [COLOR_W-1:0] vga_rgb_o,
  output logic               vga_hs_o,
  output logic               vga_vs_o,
  output logic               vga_de_o,
  output logic               frame_start_o
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_max = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] c_h_disp     = 10'(H_DISP);
  localparam logic [9:0] c_hs_start   = 10'(H_DISP + H_FP);
  localparam logic [9:0] c_hs_end     = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] c_h_max      = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_disp     = 10'(V_DISP);
  localparam logic [9:0] c_vs_start   = 10'(V_DISP + V_FP);
  localparam logic [9:0] c_vs_end     = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic [9:0] c_v_max      = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]         req_x_q, req_x_d, req_y_q, req_y_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hs_q, vs_q, de_q, fs_q, fs_d;
  logic               pix_tick, h_wrap, v_wrap;
  logic               active, next_active, hs_raw, vs_raw;

`ifdef MIXER_BORDER_EN
  logic border;
  assign border = (req_x_q == 10'd0) || (req_x_q == c_h_disp - 10'd1) ||
                  (req_y_q == 10'd0) || (req_y_q == c_v_disp - 10'd1);
`endif

  always_comb begin
    pix_tick = (div_q == c_div_max);
    div_d    = pix_tick ? '0 : div_q + 1'b1;
    h_wrap   = (h_cnt_q == c_h_max);
    v_wrap   = (v_cnt_q == c_v_max);
    h_cnt_d  = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d  = h_wrap ? (v_wrap ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
    fs_d     = pix_tick && h_wrap && v_wrap;

    active      = (h_cnt_q < c_h_disp) && (v_cnt_q < c_v_disp);
    next_active = (h_cnt_d < c_h_disp) && (v_cnt_d < c_v_disp);
    hs_raw      = !((h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end));
    vs_raw      = !((v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end));

    // Blanking keeps the last active address so layers see a stable request.
    req_x_d = next_active ? h_cnt_d : req_x_q;
    req_y_d = next_active ? v_cnt_d : req_y_q;
  end

  // Layers answer the request for the pixel currently held in the counters.
  always_comb begin
    rgb_d = '0;
    if (!active)              rgb_d = '0;
`ifdef MIXER_BORDER_EN
    else if (border)          rgb_d = '1;
`endif
    else if (me_alpha_i)      rgb_d = me_rgb_i;
    else if (enemy_alpha_i)   rgb_d = enemy_rgb_i;
    else if (bullet_alpha_i)  rgb_d = bullet_rgb_i;
    else                      rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      req_x_q <= '0;
      req_y_q <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_q <= div_d;
      fs_q  <= fs_d;
      if (pix_tick) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        req_x_q <= req_x_d;
        req_y_q <= req_y_d;
        rgb_q   <= rgb_d;
        hs_q    <= hs_raw;
        vs_q    <= vs_raw;
        de_q    <= active;
      end
    end
  end

  assign req_x_o       = req_x_q;
  assign req_y_o       = req_y_q;
  assign vga_rgb_o     = rgb_q;
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign vga_de_o      = de_q;
  assign frame_start_o = fs_q;

endmodule
`default_nettype wire

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Raster-scan driver and pixel compositor directly downstream of the bullet, player and enemy layer blocks.
- Generates VGA timing from the 250 MHz core clock and broadcasts the requested pixel address to every layer.
- Merges the returned rgb/alpha pairs by fixed priority and drives the registered VGA pins.
- Also emits a one-cycle frame-start strobe that game logic uses to step object positions.

Parameters:
- PIX_DIV, 10, core clocks per pixel (250 MHz / 10 = 25 MHz).
- H_DISP, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync pulse width.
- H_BP, 48, horizontal back porch.
- V_DISP, 480, active lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync pulse width.
- V_BP, 33, vertical back porch.
- COLOR_W, 12, RGB width (4:4:4).
- BG_COLOR, 12'h000, background colour.

Ports:
- clk  in  1  core clock, 250 MHz.
- rst  in  1  asynchronous, active-high reset.
- req_x_o  out  10  requested column 0..H_DISP-1, broadcast to layers.
- req_y_o  out  10  requested row 0..V_DISP-1.
- me_rgb_i  in  COLOR_W  player layer colour.
- me_alpha_i  in  1  player layer opaque.
- enemy_rgb_i  in  COLOR_W  enemy layer colour.
- enemy_alpha_i  in  1  enemy layer opaque.
- bullet_rgb_i  in  COLOR_W  bullet layer colour.
- bullet_alpha_i  in  1  bullet layer opaque.
- vga_rgb_o  out  COLOR_W  pixel to DAC.
- vga_hs_o  out  1  hsync, active low.
- vga_vs_o  out  1  vsync, active low.
- vga_de_o  out  1  display enable.
- frame_start_o  out  1  one-clk strobe at start of frame.

Behaviour:
- Reset values: all counters 0; req_x_o=0, req_y_o=0, vga_rgb_o=0, vga_hs_o=1, vga_vs_o=1, vga_de_o=0, frame_start_o=0.
- Pixel tick: divider counts 0..PIX_DIV-1. pix_tick=1 in the clk where the divider equals PIX_DIV-1, then it wraps to 0. All timing state advances only on pix_tick.
- Horizontal counter h_cnt runs 0..H_TOTAL-1, with H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800. Wrap at H_TOTAL-1 increments v_cnt.
- Vertical counter v_cnt runs 0..V_TOTAL-1 (525) and wraps to 0 when both counters are at max on the same tick.
- Raw timing:
  - active = (h_cnt < H_DISP) && (v_cnt < V_DISP).
  - hs_raw low for h_cnt in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC).
  - vs_raw low for v_cnt in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC).
- Request stage (stage 0): req_x_o/req_y_o are registered on pix_tick.
  - In active region they equal the h_cnt/v_cnt being entered.
  - In blanking they hold the last active value; layers may return anything.
  - Layers are combinational from req_*; their outputs are stable within 1 clk and are sampled at the next pix_tick (PIX_DIV-1 clks of settling margin).
- Compose stage (stage 1): on pix_tick, register vga_rgb_o as follows.
  - If not active_d: 0.
  - Else if me_alpha_i: me_rgb_i.
  - Else if enemy_alpha_i: enemy_rgb_i.
  - Else if bullet_alpha_i: bullet_rgb_i.
  - Else: BG_COLOR.
- Pipeline alignment: hs/vs/active are delayed one pixel tick (active_d, etc.) so vga_hs_o, vga_vs_o, vga_de_o and vga_rgb_o change in the same clk. Total latency from counter value to pin is 1 pixel (PIX_DIV clks).
- Priority is fixed (me > enemy > bullet > background). Simultaneous alphas resolve by priority only; no blending.
- frame_start_o: high for exactly one clk, at the pix_tick where h_cnt and v_cnt both wrap to 0. Never asserted during reset.
- Reset mid-frame: all outputs return to reset values immediately (async). The next frame starts at h=0, v=0 after release; the first frame_start_o comes only after a full frame (no strobe on reset exit).
- Widths: counters are 10 bits. Comparisons are unsigned; parameter sums must fit 10 bits (checked by the bench, not in RTL).

Optional Feature:
- Macro MIXER_BORDER_EN.
- Defined: any active pixel with req column 0 or H_DISP-1, or row 0 or V_DISP-1, outputs 12'hFFF, overriding all layers. Used for monitor alignment.
- Undefined: no override; border pixels follow normal priority. No extra logic is synthesised.

Test Plan:
- Release reset, run 2 frames -> hsync period 8000 clks, low for 960 clks; vsync period 4,200,000 clks, low for 16,000 clks; frame_start_o pulses exactly once per 4,200,000 clks.
- All alphas 0 -> vga_rgb_o=BG_COLOR whenever vga_de_o=1, and 0 when vga_de_o=0. vga_de_o is high for 640x480 pixel ticks per frame.
- Assert me_alpha=enemy_alpha=bullet_alpha=1 with rgb 12'hF00/12'h0F0/12'h00F -> 12'hF00. Drop me -> 12'h0F0. Drop enemy -> 12'h00F.
- Bullet model lights req_x 100..102, req_y 200..209 -> exactly 30 pixels of bullet colour appear on the pins, at the positions of those requests, one pixel tick later.
- Assert rst at h=300, v=100 for 3 clks -> outputs take reset values within the same clk. After release, the first frame_start_o arrives 4,200,000 clks later.
- With MIXER_BORDER_EN defined -> pixels (0,0), (639,0), (0,479), (639,479) and every edge pixel show 12'hFFF regardless of alphas. With the macro undefined, those pixels show BG_COLOR.
